pkt_inject_ni: RTL and testbench

Packet injection network interface that feeds one router input port (node-side injection channel). It accepts a packet descriptor plus a payload flit stream from the attached node. It segments each packet into head/body/tail flits on a chosen VC, and issues them on the router's input channel under credit-based flow control. It tracks per-VC downstream buffer credits returned on the router's outgoing flow-control signal for that port.

---
 rtl/pkt_inject_ni.sv | 157 +++++++++++++++
 tb/tb_pkt_inject_ni.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_inject_ni.sv
`default_nettype none
// ============================================================================
// pkt_inject_ni : node-side injection NI. It segments packets into flits and
// sends them on one router input channel under per-VC credit flow control.
// Rev 1.0
// ============================================================================
module pkt_inject_ni #(
    parameter int NUM_VCS            = 4,
    parameter int VC_IDX_WIDTH       = 2,
    parameter int BUFFER_SIZE        = 8,
    parameter int FLIT_DATA_WIDTH    = 64,
    parameter int MAX_PAYLOAD_LENGTH = 4,
    parameter int LEN_WIDTH          = 3
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      pkt_valid,
    output logic                                      pkt_ready,
    input  logic [VC_IDX_WIDTH-1:0]                   pkt_vc,
    input  logic [LEN_WIDTH-1:0]                      pkt_len,
    input  logic [FLIT_DATA_WIDTH-1:0]                pkt_head_data,
    input  logic                                      pay_valid,
    output logic                                      pay_ready,
    input  logic [FLIT_DATA_WIDTH-1:0]                pay_data,
    output logic [3+VC_IDX_WIDTH+FLIT_DATA_WIDTH-1:0] channel_out,
    input  logic [VC_IDX_WIDTH:0]                     flow_ctrl_in,
    output logic                                      error
);

    localparam int c_credit_width = $clog2(BUFFER_SIZE + 1);
    localparam int c_ch_width     = 3 + VC_IDX_WIDTH + FLIT_DATA_WIDTH;
    localparam logic [LEN_WIDTH-1:0]      c_max_len = LEN_WIDTH'(MAX_PAYLOAD_LENGTH);
    localparam logic [c_credit_width-1:0] c_full    = c_credit_width'(BUFFER_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    logic [VC_IDX_WIDTH-1:0]     r_vc;
    logic [LEN_WIDTH-1:0]        r_len;
    logic [LEN_WIDTH-1:0]        r_remaining;
    logic [FLIT_DATA_WIDTH-1:0]  r_head_data;
    logic [c_credit_width-1:0]   r_credit [NUM_VCS];
    logic [c_ch_width-1:0]       r_channel;
    logic                        r_error;

    logic                        w_credit_ok;
    logic                        w_accept;
    logic                        w_bad_len;
    logic                        w_send;
    logic                        w_head;
    logic                        w_tail;
    logic                        w_overflow;
    logic [FLIT_DATA_WIDTH-1:0]  w_data;
    logic [NUM_VCS-1:0]          w_ret;
    logic [NUM_VCS-1:0]          w_use;

    assign w_credit_ok = (r_credit[r_vc] != '0);
    assign w_bad_len   = (pkt_len > c_max_len);
    assign channel_out = r_channel;
    assign error       = r_error;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_send       = 1'b0;
        w_head       = 1'b0;
        w_tail       = 1'b0;
        w_data       = r_head_data;
        pkt_ready    = 1'b0;
        pay_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                pkt_ready = reset;
                w_accept  = pkt_valid && reset;
                if (w_accept) w_next_state = HEAD;
            end
            HEAD: begin
                if (w_credit_ok) begin
                    w_send       = 1'b1;
                    w_head       = 1'b1;
                    w_tail       = (r_len == '0);
                    w_next_state = w_tail ? IDLE : BODY;
                end
            end
            BODY: begin
                // Ready depends only on credit so a stalled flit is never consumed.
                pay_ready = w_credit_ok && reset;
                if (pay_valid && w_credit_ok) begin
                    w_send = 1'b1;
                    w_tail = (r_remaining == LEN_WIDTH'(1));
                    w_data = pay_data;
                    if (w_tail) w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_ret      = '0;
        w_use      = '0;
        w_overflow = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            w_ret[v] = flow_ctrl_in[VC_IDX_WIDTH] &&
                       (flow_ctrl_in[VC_IDX_WIDTH-1:0] == VC_IDX_WIDTH'(v));
            w_use[v] = w_send && (r_vc == VC_IDX_WIDTH'(v));
            if (w_ret[v] && !w_use[v] && (r_credit[v] == c_full)) w_overflow = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VCS; v++) r_credit[v] <= c_full;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (w_use[v] && !w_ret[v])
                    r_credit[v] <= r_credit[v] - 1'b1;
                else if (w_ret[v] && !w_use[v] && (r_credit[v] != c_full))
                    r_credit[v] <= r_credit[v] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_vc        <= '0;
            r_len       <= '0;
            r_remaining <= '0;
            r_head_data <= '0;
            r_channel   <= '0;
            r_error     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_vc        <= pkt_vc;
                r_head_data <= pkt_head_data;
                r_len       <= w_bad_len ? c_max_len : pkt_len;
            end
            if (w_send) begin
                r_remaining <= (r_state == HEAD) ? r_len : r_remaining - 1'b1;
                r_channel   <= {1'b1, r_vc, w_head, w_tail, w_data};
            end else begin
                // Only valid drops; the remaining fields keep their last value.
                r_channel[c_ch_width-1] <= 1'b0;
            end
            if ((w_accept && w_bad_len) || w_overflow) r_error <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pkt_inject_ni.sv
`default_nettype none
// ============================================================================
// tb_pkt_inject_ni : self-checking bench for pkt_inject_ni.
// Rev 1.0
// ============================================================================
module tb_pkt_inject_ni;
    localparam int VW  = 2;
    localparam int DW  = 64;
    localparam int CHW = 3 + VW + DW;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            pkt_valid = 1'b0;
    logic            pkt_ready;
    logic [VW-1:0]   pkt_vc = '0;
    logic [2:0]      pkt_len = '0;
    logic [DW-1:0]   pkt_head_data = '0;
    logic            pay_valid = 1'b0;
    logic            pay_ready;
    logic [DW-1:0]   pay_data = '0;
    logic [CHW-1:0]  channel_out;
    logic [VW:0]     flow_ctrl_in = '0;
    logic            error;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    pkt_inject_ni dut (
        .clk(clk), .reset(reset),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_vc(pkt_vc),
        .pkt_len(pkt_len), .pkt_head_data(pkt_head_data),
        .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
        .channel_out(channel_out), .flow_ctrl_in(flow_ctrl_in), .error(error)
    );

    function automatic logic [CHW-1:0] flit(input logic [VW-1:0] vc, input logic h,
                                            input logic t, input logic [DW-1:0] d);
        return {1'b1, vc, h, t, d};
    endfunction

    // Random-test reference: expected flit order and flits held in the router per VC.
    logic [CHW-1:0] exp_q[$];
    logic [DW-1:0]  pay_q[$];
    int             outstanding[4];
    bit             rand_en = 1'b0;
    int             got;
    logic [CHW-1:0] mon_e;
    int             mon_v;
    int             ret_v;

    always @(negedge clk) begin
        if (rand_en) begin
            if (channel_out[CHW-1]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_flit: unexpected flit %h", channel_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (channel_out !== mon_e)
                        $display("FAIL rand_flit: got %h expected %h", channel_out, mon_e);
                    else passes++;
                end
                mon_v = int'(channel_out[CHW-2 -: VW]);
                outstanding[mon_v]++;
                checks++;
                if (outstanding[mon_v] > 8)
                    $display("FAIL rand_credit_bound: vc %0d holds %0d flits, limit 8", mon_v, outstanding[mon_v]);
                else passes++;
                got++;
            end
            flow_ctrl_in = '0;
            if ($urandom_range(0, 1) == 1) begin
                ret_v = int'($urandom_range(0, 3));
                if (outstanding[ret_v] > 0) begin
                    flow_ctrl_in = {1'b1, ret_v[VW-1:0]};
                    outstanding[ret_v]--;
                end
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b0;
        pkt_valid = 1'b0;
        pay_valid = 1'b0;
        flow_ctrl_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Returns #1 after the accepting edge, i.e. inside the HEAD cycle.
    task automatic send_desc(input int vc, input int len, input logic [DW-1:0] hd);
        int n = 0;
        @(negedge clk);
        pkt_valid = 1'b1;
        pkt_vc = vc[VW-1:0];
        pkt_len = len[2:0];
        pkt_head_data = hd;
        while (!pkt_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) $display("FAIL desc_accept: pkt_ready low for %0d cycles, required high", n);
        else passes++;
        @(posedge clk);
        #1 pkt_valid = 1'b0;
    endtask

    task automatic run_cycles(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (channel_out[CHW-1]) cnt++;
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        pkt_valid = 1'b1;
        #3;
        checks++;
        if (channel_out !== '0 || error !== 1'b0)
            $display("FAIL reset_outputs: channel %h error %b, required 0 0", channel_out, error);
        else passes++;
        checks++;
        if (pkt_ready !== 1'b0 || pay_ready !== 1'b0)
            $display("FAIL reset_ready: pkt_ready %b pay_ready %b, required 0 0", pkt_ready, pay_ready);
        else passes++;
        pkt_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (pkt_ready !== 1'b1) $display("FAIL reset_release_ready: pkt_ready %b, required 1", pkt_ready);
        else passes++;
        for (int v = 0; v < 4; v++) begin
            checks++;
            if (dut.r_credit[v] !== 4'd8)
                $display("FAIL reset_credit: vc %0d credit %0d, required 8", v, dut.r_credit[v]);
            else passes++;
        end
    endtask

    task automatic test_single_flit();
        apply_reset();
        send_desc(2, 0, 64'hA5);
        checks++;
        if (channel_out[CHW-1] !== 1'b0 || pkt_ready !== 1'b0)
            $display("FAIL single_head_cycle: valid %b pkt_ready %b, required 0 0", channel_out[CHW-1], pkt_ready);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (channel_out !== flit(2'd2, 1'b1, 1'b1, 64'hA5))
            $display("FAIL single_flit: got %h expected %h", channel_out, flit(2'd2, 1'b1, 1'b1, 64'hA5));
        else passes++;
        checks++;
        if (pkt_ready !== 1'b1 || dut.r_credit[2] !== 4'd7)
            $display("FAIL single_after: pkt_ready %b credit2 %0d, required 1 7", pkt_ready, dut.r_credit[2]);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (channel_out[CHW-1] !== 1'b0) $display("FAIL single_once: valid %b, required 0", channel_out[CHW-1]);
        else passes++;
    endtask

    task automatic test_multi_flit();
        logic [CHW-1:0] fl[8];
        logic [CHW-1:0] ex[4];
        int cyc[8];
        int nf = 0;
        int rdy = 0;
        int consumed = 0;
        ex[0] = flit(2'd1, 1'b1, 1'b0, 64'hC0DE);
        ex[1] = flit(2'd1, 1'b0, 1'b0, 64'd1);
        ex[2] = flit(2'd1, 1'b0, 1'b0, 64'd2);
        ex[3] = flit(2'd1, 1'b0, 1'b1, 64'd3);
        apply_reset();
        pay_valid = 1'b1;
        pay_data = 64'd1;
        send_desc(1, 3, 64'hC0DE);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (channel_out[CHW-1]) begin
                fl[nf] = channel_out;
                cyc[nf] = i;
                nf++;
            end
            pay_data = 64'(consumed + 1);
            if (pay_ready) begin
                rdy++;
                consumed++;
            end
        end
        pay_valid = 1'b0;
        checks++;
        if (nf != 4) $display("FAIL multi_count: %0d flits, required 4", nf);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= nf || fl[i] !== ex[i])
                $display("FAIL multi_flit%0d: got %h expected %h", i, (i < nf) ? fl[i] : '0, ex[i]);
            else passes++;
        end
        checks++;
        if (nf != 4 || cyc[3] - cyc[0] != 3)
            $display("FAIL multi_back_to_back: span %0d cycles, required 3", (nf == 4) ? cyc[3] - cyc[0] : -1);
        else passes++;
        checks++;
        if (rdy != 3 || dut.r_credit[1] !== 4'd4)
            $display("FAIL multi_ready_credit: pay_ready cycles %0d credit1 %0d, required 3 4", rdy, dut.r_credit[1]);
        else passes++;
    endtask

    task automatic test_exhaustion();
        int n1, n2, bad;
        apply_reset();
        pay_valid = 1'b1;
        pay_data = 64'hBEEF;
        send_desc(0, 3, 64'h11);
        run_cycles(8, n1);
        send_desc(0, 4, 64'h22);
        run_cycles(10, n2);
        checks++;
        if (n1 + n2 != 8) $display("FAIL exhaust_count: %0d flits, required 8", n1 + n2);
        else passes++;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (channel_out[CHW-1] !== 1'b0 || pay_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL exhaust_stall: %0d stall cycles active, required 0", bad);
        else passes++;
        flow_ctrl_in = {1'b1, 2'd0};
        @(negedge clk);
        flow_ctrl_in = '0;
        checks++;
        if (pay_ready !== 1'b1 || channel_out[CHW-1] !== 1'b0)
            $display("FAIL exhaust_credit_cycle: pay_ready %b valid %b, required 1 0", pay_ready, channel_out[CHW-1]);
        else passes++;
        @(negedge clk);
        checks++;
        if (channel_out !== flit(2'd0, 1'b0, 1'b1, 64'hBEEF))
            $display("FAIL exhaust_release: got %h expected %h", channel_out, flit(2'd0, 1'b0, 1'b1, 64'hBEEF));
        else passes++;
        checks++;
        if (dut.r_credit[0] !== 4'd0) $display("FAIL exhaust_credit: credit0 %0d, required 0", dut.r_credit[0]);
        else passes++;
        pay_valid = 1'b0;
    endtask

    task automatic test_same_cycle();
        int n;
        apply_reset();
        pay_valid = 1'b1;
        pay_data = 64'h33;
        send_desc(0, 0, 64'h10);
        run_cycles(4, n);
        send_desc(3, 2, 64'h30);
        run_cycles(6, n);
        send_desc(3, 1, 64'h31);
        flow_ctrl_in = {1'b1, 2'd3};
        @(posedge clk); #1;
        checks++;
        if (dut.r_credit[3] !== 4'd5) $display("FAIL same_vc_credit: credit3 %0d, required 5", dut.r_credit[3]);
        else passes++;
        flow_ctrl_in = {1'b1, 2'd0};
        @(posedge clk); #1;
        flow_ctrl_in = '0;
        checks++;
        if (dut.r_credit[0] !== 4'd8 || dut.r_credit[3] !== 4'd4 || error !== 1'b0)
            $display("FAIL cross_vc_credit: credit0 %0d credit3 %0d error %b, required 8 4 0",
                     dut.r_credit[0], dut.r_credit[3], error);
        else passes++;
        pay_valid = 1'b0;
    endtask

    task automatic test_errors();
        int n;
        apply_reset();
        @(negedge clk);
        flow_ctrl_in = {1'b1, 2'd1};
        @(negedge clk);
        flow_ctrl_in = '0;
        checks++;
        if (error !== 1'b1 || dut.r_credit[1] !== 4'd8)
            $display("FAIL overflow: error %b credit1 %0d, required 1 8", error, dut.r_credit[1]);
        else passes++;
        pay_valid = 1'b1;
        pay_data = 64'h44;
        send_desc(1, 2, 64'h40);
        run_cycles(6, n);
        checks++;
        if (n != 3 || error !== 1'b1 || dut.r_credit[1] !== 4'd5)
            $display("FAIL overflow_sticky: flits %0d error %b credit1 %0d, required 3 1 5", n, error, dut.r_credit[1]);
        else passes++;
        apply_reset();
        #1;
        checks++;
        if (error !== 1'b0) $display("FAIL error_clear: error %b, required 0", error);
        else passes++;
        pay_valid = 1'b1;
        send_desc(2, 6, 64'h60);
        run_cycles(10, n);
        checks++;
        if (n != 5 || error !== 1'b1 || dut.r_credit[2] !== 4'd3)
            $display("FAIL illegal_len: flits %0d error %b credit2 %0d, required 5 1 3", n, error, dut.r_credit[2]);
        else passes++;
        pay_valid = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        int n;
        apply_reset();
        pay_valid = 1'b1;
        pay_data = 64'h5;
        send_desc(2, 4, 64'h50);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (channel_out !== flit(2'd2, 1'b0, 1'b0, 64'h5))
            $display("FAIL midreset_body: got %h expected %h", channel_out, flit(2'd2, 1'b0, 1'b0, 64'h5));
        else passes++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (channel_out !== '0 || pkt_ready !== 1'b0 || pay_ready !== 1'b0)
            $display("FAIL midreset_async: channel %h pkt_ready %b pay_ready %b, required 0 0 0",
                     channel_out, pkt_ready, pay_ready);
        else passes++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        for (int v = 0; v < 4; v++) begin
            checks++;
            if (dut.r_credit[v] !== 4'd8)
                $display("FAIL midreset_credit: vc %0d credit %0d, required 8", v, dut.r_credit[v]);
            else passes++;
        end
        checks++;
        if (pkt_ready !== 1'b1 || error !== 1'b0)
            $display("FAIL midreset_ready: pkt_ready %b error %b, required 1 0", pkt_ready, error);
        else passes++;
        pay_data = 64'h9;
        send_desc(3, 1, 64'h90);
        run_cycles(6, n);
        checks++;
        if (n != 2 || dut.r_credit[3] !== 4'd6)
            $display("FAIL midreset_new_packet: flits %0d credit3 %0d, required 2 6", n, dut.r_credit[3]);
        else passes++;
        pay_valid = 1'b0;
    endtask

    task automatic test_random();
        int dvc[30];
        int dlen[30];
        logic [DW-1:0] dhd[30];
        int n_exp;
        int cyc;
        apply_reset();
        exp_q.delete();
        pay_q.delete();
        for (int v = 0; v < 4; v++) outstanding[v] = 0;
        got = 0;
        for (int i = 0; i < 30; i++) begin
            dvc[i] = int'($urandom_range(0, 3));
            dlen[i] = int'($urandom_range(0, 4));
            dhd[i] = {$urandom, $urandom};
            exp_q.push_back(flit(dvc[i][VW-1:0], 1'b1, dlen[i] == 0, dhd[i]));
            for (int j = 0; j < dlen[i]; j++) begin
                logic [DW-1:0] d;
                d = {$urandom, $urandom};
                pay_q.push_back(d);
                exp_q.push_back(flit(dvc[i][VW-1:0], 1'b0, j == dlen[i] - 1, d));
            end
        end
        n_exp = exp_q.size();
        rand_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send_desc(dvc[i], dlen[i], dhd[i]);
                end
            end
            begin
                int idx = 0;
                int pc = 0;
                while (idx < pay_q.size() && pc < 5000) begin
                    @(negedge clk);
                    pc++;
                    pay_valid = ($urandom_range(0, 3) != 0);
                    pay_data = pay_q[idx];
                    if (pay_valid && pay_ready) idx++;
                end
                @(negedge clk);
                pay_valid = 1'b0;
            end
        join
        cyc = 0;
        while (got < n_exp && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (got != n_exp) $display("FAIL rand_complete: %0d flits seen, required %0d", got, n_exp);
        else passes++;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rand_en = 1'b0;
        flow_ctrl_in = '0;
        @(posedge clk); #1;
        for (int v = 0; v < 4; v++) begin
            checks++;
            if (int'(dut.r_credit[v]) != 8 - outstanding[v])
                $display("FAIL rand_credit: vc %0d credit %0d, required %0d", v, dut.r_credit[v], 8 - outstanding[v]);
            else passes++;
        end
        checks++;
        if (error !== 1'b0) $display("FAIL rand_error: error %b, required 0", error);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_multi_flit();
        test_exhaustion();
        test_same_cycle();
        test_errors();
        test_reset_mid_packet();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
